// File: rtl/loop_select_sched.sv
// Multi-cycle iteration scheduler for the signed compare/select kernel.
// One kernel iteration per clock, with a start/busy/done handshake and abort.
module loop_select_sched #(
  parameter  int CNT_W  = 3,
  parameter  int DATA_W = 6,
  localparam int RES_W  = 2**CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] operand,
  input  logic [CNT_W-1:0]  bound,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  iter_idx,
  output logic [RES_W-1:0]  res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]  bound_q, bound_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RES_W-1:0]  res_q, res_d;

  // Kernel operands: the counter is zero-extended so the compare is signed
  // against a non-negative value, one bit wider than the operand.
  logic signed [DATA_W:0] op_ext;
  logic signed [DATA_W:0] cnt_ext;
  logic                   cmp;
  logic [CNT_W-1:0]       neg;
  logic                   kbit;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   last_iter;

  always_comb begin
    op_ext    = {op_q[DATA_W-1], op_q};
    cnt_ext   = {{(DATA_W+1-CNT_W){1'b0}}, cnt_q};
    cmp       = (op_ext <= cnt_ext);
    neg       = -cnt_q;
    kbit      = cmp ? (^neg) : (~^op_q[CNT_W-1:0]);
    cnt_inc   = cnt_q + CNT_W'(1);
    last_iter = (cnt_inc == bound_q);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bound_d = bound_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = operand;
          bound_d = bound;
          cnt_d   = '0;
          res_d   = '0;
          state_d = (bound == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over the iteration: nothing is written this cycle.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          res_d[cnt_q] = kbit;
          cnt_d        = cnt_inc;
          if (last_iter) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      bound_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bound_q <= bound_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign iter_idx = cnt_q;
  assign res      = res_q;

endmodule

// File: tb/tb_loop_select_sched.sv
// Directed bench for loop_select_sched with hand-computed expected results.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_loop_select_sched;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [5:0] operand;
  logic [2:0] bound;
  logic       busy;
  logic       done;
  logic [2:0] iter_idx;
  logic [7:0] res;

  int n_checks = 0;
  int n_errors = 0;

  loop_select_sched #(.CNT_W(3), .DATA_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .operand  (operand),
    .bound    (bound),
    .busy     (busy),
    .done     (done),
    .iter_idx (iter_idx),
    .res      (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a loop and check every cycle through the done pulse.
  task automatic run_loop(input logic [5:0] op, input logic [2:0] bnd,
                          input logic [7:0] exp_res, input string tag);
    logic [7:0] mask;
    @(negedge clk);
    start = 1'b1; operand = op; bound = bnd;
    @(negedge clk);
    start = 1'b0; operand = '0; bound = '0;
    for (int k = 1; k <= int'(bnd); k++) begin
      mask = (8'd1 << (k - 1)) - 8'd1;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_nodone"}, done, 0);
      check({tag, "_idx"}, iter_idx, k - 1);
      check({tag, "_partial"}, res, exp_res & mask);
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_idx_final"}, iter_idx, bnd);
    @(negedge clk);
    check({tag, "_done_once"}, done, 0);
    check({tag, "_res_hold"}, res, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; operand = '0; bound = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", res, 8'h00);
    check("rst_idx", iter_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // All cmp=0, ~^101=1.
    run_loop(6'd5, 3'd4, 8'h0F, "op5_b4");
    // Directly after 0F: res must clear on start; bits 0,0,0,0.
    run_loop(6'd2, 3'd4, 8'h00, "op2_b4");
    // op=-1: all cmp=1, bits ^neg = 0,1,0.
    run_loop(6'h3F, 3'd3, 8'h02, "opm1_b3");
    // op=-32 must compare signed: bits 0,1,0,0.
    run_loop(6'h20, 3'd4, 8'h02, "opm32_b4");
    // op=3: bits 1,1,1,0,1.
    run_loop(6'd3, 3'd5, 8'h17, "op3_b5");
    // Max bound: bits 1,1,1,1,1,0,1; counter ends at 7.
    run_loop(6'd5, 3'd7, 8'h5F, "op5_b7");
    // Zero bound: done next cycle, no busy, res 0.
    run_loop(6'd5, 3'd0, 8'h00, "op5_b0");

    // Start held high through RUN and DONE: only one loop, one done.
    @(negedge clk);
    start = 1'b1; operand = 6'd5; bound = 3'd2;
    @(negedge clk);
    operand = 6'h3F; bound = 3'd0;
    check("hold_busy1", busy, 1);
    @(negedge clk);
    check("hold_busy2", busy, 1);
    @(negedge clk);
    check("hold_done", done, 1);
    check("hold_res", res, 8'h03);
    start = 1'b0;
    @(negedge clk);
    check("hold_single_done", done, 0);
    check("hold_idle", busy, 0);

    // Abort in the third RUN cycle keeps bits 0 and 1 only.
    @(negedge clk);
    start = 1'b1; operand = 6'd5; bound = 3'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_pre", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_nodone", done, 0);
    check("abort_res", res, 8'h03);
    @(negedge clk);
    check("abort_nodone2", done, 0);
    check("abort_res_hold", res, 8'h03);
    run_loop(6'd3, 3'd5, 8'h17, "after_abort");

    // Abort while idle is ignored.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_res", res, 8'h17);

    // Reset asserted mid-RUN returns to reset values at once.
    @(negedge clk);
    start = 1'b1; operand = 6'd5; bound = 3'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_res", res, 8'h00);
    check("mid_rst_idx", iter_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    @(negedge clk);
    check("post_rst_done2", done, 0);
    run_loop(6'h3F, 3'd3, 8'h02, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
